// File: rtl/comparator_serial.sv
// comparator_serial: bit-serial magnitude comparator, MSB first with early exit.
// Operands are captured on an accepted start. One bit pair is examined per
// clock until the first difference, or until bit 0 if the operands are equal.
// Optional feature macro: COMPARATOR_SIGNED_EN adds an 'sgn' input that selects
// a two's complement compare, captured together with the operands.
module comparator_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef COMPARATOR_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic             AeqB,
    output logic             AgtB,
    output logic             AltB
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             eq_reg, eq_next;
    logic             gt_reg, gt_next;
    logic             lt_reg, lt_next;
    logic             sgn_reg;
`ifdef COMPARATOR_SIGNED_EN
    logic             sgn_next;
`else
    // Unsigned-only build: the sign-select is permanently off.
    assign sgn_reg = 1'b0;
`endif

    // Per-bit difference vector of the captured operands.
    logic [WIDTH-1:0] diff_vec;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
            assign diff_vec[gi] = a_reg[gi] ^ b_reg[gi];
        end
    endgenerate

    // In a signed compare a difference at the sign bit inverts the winner.
    logic a_bit;
    logic msb_flip;
    logic a_wins;
    assign a_bit    = a_reg[idx_reg];
    assign msb_flip = sgn_reg && (idx_reg == TOP_IDX);
    assign a_wins   = a_bit ^ msb_flip;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        eq_next    = eq_reg;
        gt_next    = gt_reg;
        lt_next    = lt_reg;
`ifdef COMPARATOR_SIGNED_EN
        sgn_next   = sgn_reg;
`endif
        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    a_next     = A;
                    b_next     = B;
`ifdef COMPARATOR_SIGNED_EN
                    sgn_next   = sgn;
`endif
                    idx_next   = TOP_IDX;
                    state_next = CMP;
                    busy_next  = 1'b1;
                    eq_next    = 1'b0;
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                end
            end
            CMP: begin
                if (diff_vec[idx_reg]) begin
                    // First differing bit decides the result immediately.
                    gt_next    = a_wins;
                    lt_next    = ~a_wins;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else if (idx_reg == '0) begin
                    eq_next    = 1'b1;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg - IW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= TOP_IDX;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
`ifdef COMPARATOR_SIGNED_EN
            sgn_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            eq_reg    <= eq_next;
            gt_reg    <= gt_next;
            lt_reg    <= lt_next;
`ifdef COMPARATOR_SIGNED_EN
            sgn_reg   <= sgn_next;
`endif
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign AeqB = eq_reg;
    assign AgtB = gt_reg;
    assign AltB = lt_reg;

endmodule

// File: tb/tb_comparator_serial.sv
// tb_comparator_serial: scoreboard bench for comparator_serial (WIDTH=8).
// A reference process predicts each accepted compare from plain arithmetic and
// queues the expected result; a monitor pops and compares on every done pulse.
module tb_comparator_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         sgn_in = 1'b0;
    logic         busy, done, AeqB, AgtB, AltB;

    comparator_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
`ifdef COMPARATOR_SIGNED_EN
        .sgn   (sgn_in),
`endif
        .busy  (busy),
        .done  (done),
        .AeqB  (AeqB),
        .AgtB  (AgtB),
        .AltB  (AltB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [2:0]   flags;   // {eq, gt, lt}
        int           end_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   tx_count = 0;

    // Reference model state, advanced once per rising edge.
    int         cyc = 0;
    bit         m_idle = 1'b1;
    int         m_end = 0;
    logic [2:0] m_res = 3'b000;
    logic [2:0] exp_flags = 3'b000;
    bit         exp_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Expected result of one compare from ordinary integer comparison.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (a == b) return 3'b100;
        if (s) return ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
        return (a > b) ? 3'b010 : 3'b001;
    endfunction

    // Cycles from accept to done: WIDTH minus highest differing bit, WIDTH if equal.
    function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        int d;
        x = a ^ b;
        if (x == '0) return W;
        d = 0;
        for (int i = 0; i < W; i++) if (x[i]) d = i;
        return W - d;
    endfunction

    // Reference process: predicts acceptance, completion and reset behaviour.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            exp_done = 1'b0;
            if (!rst_n) begin
                m_idle = 1'b1;
                exp_flags = 3'b000;
                sb.delete();
            end else if (!m_idle && cyc == m_end) begin
                m_idle = 1'b1;
                exp_flags = m_res;
                exp_done = 1'b1;
            end else if (m_idle && start) begin
                exp_t e;
                logic s_eff;
`ifdef COMPARATOR_SIGNED_EN
                s_eff = sgn_in;
`else
                s_eff = 1'b0;
`endif
                e.a = a_in;
                e.b = b_in;
                e.s = s_eff;
                e.flags = ref_flags(a_in, b_in, s_eff);
                e.end_cyc = cyc + ref_latency(a_in, b_in);
                sb.push_back(e);
                m_res = e.flags;
                m_end = e.end_cyc;
                m_idle = 1'b0;
                exp_flags = 3'b000;
            end
        end
    end

    // Monitor: per-cycle status checks, and scoreboard pop on each done pulse.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", 64'(busy), 64'(!m_idle));
            check("done", 64'(done), 64'(exp_done));
            check("flags", 64'({AeqB, AgtB, AltB}), 64'(exp_flags));
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    tx_count++;
                    $display("tx %0d A=%02h B=%02h sgn=%0d flags(eq,gt,lt)=%03b cycle=%0d",
                             tx_count, e.a, e.b, e.s, {AeqB, AgtB, AltB}, cyc);
                    check("tx_flags", 64'({AeqB, AgtB, AltB}), 64'(e.flags));
                    check("tx_done_cycle", 64'(cyc), 64'(e.end_cyc));
                end
            end
        end
    end

    // Drive one start pulse; call just after a falling edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        a_in = a;
        b_in = b;
        sgn_in = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = ~a;   // later operand changes must have no effect
        b_in = ~b;
    endtask

    // Wait (bounded) until the model is idle again.
    task automatic wait_idle();
        int n;
        n = 0;
        while (!m_idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!m_idle) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout at cycle %0d: busy=%0d expected idle", cyc, busy);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Start accepted on the first edge after reset release; early exit at MSB.
        issue(8'hA5, 8'h25, 1'b0);
        wait_idle();
        issue(8'h3C, 8'h3C, 1'b0);
        wait_idle();
        issue(8'h10, 8'h11, 1'b0);
        wait_idle();

        // Start held high: back-to-back compares, operands churn while busy.
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            if (m_idle) begin
                a_in = 8'h01;
                b_in = 8'h00;
            end else begin
                a_in = W'($urandom);
                b_in = W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Reset during the third CMP cycle, then an immediate restart.
        issue(8'h00, 8'h01, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h00, 8'h01, 1'b0);
        wait_idle();

`ifdef COMPARATOR_SIGNED_EN
        issue(8'h80, 8'h01, 1'b1);
        wait_idle();
        issue(8'h80, 8'h01, 1'b0);
        wait_idle();
`endif

        // Randomized traffic with near-equal operands and occasional resets.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            int sel;
            a = W'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0) b = a;
            else if (sel == 1) b = a ^ (W'(1) << $urandom_range(0, W - 1));
            else b = W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b, 1'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comparator_serial.md
COMPARATOR_SERIAL -- requirements
Module: comparator_serial

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a compare of A and B.
REQ-005 SHALL have ports: A and B  input  WIDTH  operands, sampled only when start is accepted.
REQ-006 SHALL have port: busy  output  1  high while a compare is in progress.
REQ-007 SHALL have port: done  output  1  one-cycle pulse when the result becomes valid.
REQ-008 SHALL have ports: AeqB, AgtB and AltB  output  1  each  result flags (A==B, A>B, A<B).
REQ-009 SHALL have all outputs registered, with no combinational path from inputs to outputs.

Function
REQ-010 SHALL use FSM states IDLE and CMP only.
REQ-011 SHALL, in IDLE with start=1 at an edge: capture A and B into internal registers; set bit index to WIDTH-1; go to CMP; set busy=1; clear AeqB, AgtB and AltB to 0.
REQ-012 SHALL, in IDLE with start=0: hold state; busy=0; result flags hold their last value.
REQ-013 SHALL, in CMP, examine at each edge the captured bits at the current index, MSB first.
REQ-014 SHALL, in CMP, on the first differing bit: set AgtB=1 if A bit=1, else AltB=1; pulse done=1; set busy=0; return to IDLE (early termination).
REQ-015 SHALL, in CMP, with bits equal and index>0: decrement index and stay in CMP.
REQ-016 SHALL, in CMP, with bits equal and index=0: set AeqB=1; pulse done=1; set busy=0; return to IDLE.
REQ-017 SHALL give latency from the accepting edge to the done edge of WIDTH-d cycles, where d is the highest differing bit; for equal operands the latency SHALL be WIDTH cycles.
REQ-018 SHALL ignore start while busy=1, and SHALL ignore changes on A and B after capture.
REQ-019 SHALL accept start=1 in the cycle where done=1, since the state is already IDLE: flags clear and a new compare begins at that edge.
REQ-020 SHALL keep exactly one flag high from the done edge until the next accepted start, and SHALL keep all flags 0 while busy=1.
REQ-021 SHALL keep done high for exactly one cycle per compare and never while busy=1.

Reset
REQ-022 SHALL, at an edge with rst_n=0: set state to IDLE, busy=0, done=0, AeqB=0, AgtB=0, AltB=0, index=WIDTH-1, and clear the captured operands.
REQ-023 SHALL abandon a compare in progress on reset with no done pulse; reset SHALL take priority over start.
REQ-024 SHALL accept start at the first edge after rst_n returns high.

Configuration
REQ-025 SHALL, with COMPARATOR_SIGNED_EN defined, add port: sgn  input  1, captured together with A and B at start.
REQ-026 SHALL, with sgn=1, compare as two's complement: a difference at bit WIDTH-1 gives AltB=1 if A bit=1, else AgtB=1; lower bits SHALL behave as in REQ-014.
REQ-027 SHALL, with COMPARATOR_SIGNED_EN undefined, have no sgn port and compare unsigned only; behaviour SHALL then equal the sgn=0 case.

Verification (WIDTH=8)
REQ-028 SHALL cover: A=0xA5, B=0x25, start pulse -> done 1 cycle after accept, AgtB=1, others 0.
REQ-029 SHALL cover: A=B=0x3C -> busy for 8 cycles, done on the 8th edge, AeqB=1; A=0x10, B=0x11 -> done on the 8th edge, AltB=1.
REQ-030 SHALL cover: start held high for 20 cycles with A=0x01, B=0x00 -> back-to-back compares each 8 cycles; operand changes while busy have no effect.
REQ-031 SHALL cover: rst_n=0 at the 3rd CMP cycle of A=0x00, B=0x01 -> no done; all outputs 0 the next cycle; the following start completes normally.
REQ-032 SHALL cover, with COMPARATOR_SIGNED_EN: A=0x80, B=0x01 -> sgn=1 gives AltB after 1 cycle; sgn=0 gives AgtB after 1 cycle.
